// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 channel multiplexer with per-channel valid/ready handshakes.
// Grant comes from an explicit select (MODE 0) or a round-robin scan (MODE 1).
module mux_nto1_reg #(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int MODE     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CHANNELS*SIZE-1:0] data_i,
  input  logic [CHANNELS-1:0]      valid_i,
  output logic [CHANNELS-1:0]      ready_o,
  input  logic [SEL_W-1:0]         select_i,
  output logic [SIZE-1:0]          data_o,
  output logic                     valid_o,
  output logic [SEL_W-1:0]         chan_o,
  input  logic                     ready_i
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             slot_free;
  logic             transfer;
  logic [SIZE-1:0]  grant_data;

  assign slot_free = !valid_o || ready_i;

  // The round-robin scan runs from the highest offset down, so the nearest
  // valid channel after ptr is the last one written and wins.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_s       = '0;
    if (MODE == 0) begin
      if (int'(select_i) < CHANNELS) begin
        if (valid_i[select_i]) begin
          grant       = select_i;
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int i = CHANNELS; i >= 1; i--) begin
        idx   = (int'(ptr) + i) % CHANNELS;
        idx_s = SEL_W'(idx);
        if (valid_i[idx_s]) begin
          grant       = idx_s;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready_o    = '0;
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data = data_i[k*SIZE +: SIZE];
        ready_o[k] = grant_valid && slot_free && !rst_i;
      end
    end
  end

  assign transfer = |(valid_i & ready_o);

  // Output slot: a transfer replaces the entry, a bare consume only clears valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      chan_o  <= '0;
      ptr     <= SEL_W'(CHANNELS - 1);
    end else if (transfer) begin
      valid_o <= 1'b1;
      data_o  <= grant_data;
      chan_o  <= grant;
      if (MODE == 1) ptr <= grant;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: explicit select, back-pressure, round-robin,
// mid-operation reset and an out-of-range select on a 3-channel instance.
module tb_mux_nto1_reg;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  // u0: explicit select, 4 channels
  logic [127:0] d0;
  logic [3:0]   v0, rdy0;
  logic [1:0]   s0, c0;
  logic [31:0]  q0;
  logic         vo0, r0;

  // u1: round-robin, 4 channels
  logic [127:0] d1;
  logic [3:0]   v1, rdy1;
  logic [1:0]   s1, c1;
  logic [31:0]  q1;
  logic         vo1, r1;

  // u3: explicit select, 3 channels
  logic [95:0]  d3;
  logic [2:0]   v3, rdy3;
  logic [1:0]   s3, c3;
  logic [31:0]  q3;
  logic         vo3, r3;

  int checks = 0;
  int errors = 0;

  mux_nto1_reg #(.SIZE(32), .CHANNELS(4), .MODE(0)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(d0), .valid_i(v0), .ready_o(rdy0),
    .select_i(s0), .data_o(q0), .valid_o(vo0), .chan_o(c0), .ready_i(r0));

  mux_nto1_reg #(.SIZE(32), .CHANNELS(4), .MODE(1)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(d1), .valid_i(v1), .ready_o(rdy1),
    .select_i(s1), .data_o(q1), .valid_o(vo1), .chan_o(c1), .ready_i(r1));

  mux_nto1_reg #(.SIZE(32), .CHANNELS(3), .MODE(0)) u3 (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(d3), .valid_i(v3), .ready_o(rdy3),
    .select_i(s3), .data_o(q3), .valid_o(vo3), .chan_o(c3), .ready_i(r3));

  // Advance one rising edge and leave a settle gap before sampling/driving.
  task automatic applyStimulus();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle3();
    checkOutput("u3_ready_oor", {29'd0, rdy3}, 32'h0);
    checkOutput("u3_valid_oor", {31'd0, vo3}, 32'h0);
  endtask

  initial begin
    int rr_a[6];
    int rr_b[5];
    rr_a = '{0, 1, 2, 3, 0, 1};
    rr_b = '{2, 3, 0, 2, 3};

    rst_i = 1'b1;
    d0 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    d1 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    d3 = {32'hC2, 32'hC1, 32'hC0};
    v0 = 4'hF; v1 = 4'hF; v3 = 3'b111;
    s0 = 2'd0; s1 = 2'd0; s3 = 2'd3;
    r0 = 1'b1; r1 = 1'b1; r3 = 1'b1;

    // Reset state, with everything valid and ready_i high
    applyStimulus();
    applyStimulus();
    checkOutput("rst_ready0", {28'd0, rdy0}, 32'h0);
    checkOutput("rst_ready1", {28'd0, rdy1}, 32'h0);
    checkOutput("rst_valid0", {31'd0, vo0}, 32'h0);
    checkOutput("rst_data0", q0, 32'h0);
    checkOutput("rst_chan0", {30'd0, c0}, 32'h0);
    checkOutput("rst_valid1", {31'd0, vo1}, 32'h0);

    v1 = 4'h0;
    rst_i = 1'b0;

    // Explicit select stepping 0..3
    for (int k = 0; k < 4; k++) begin
      s0 = 2'(k);
      #1;
      checkOutput("sel_ready", {28'd0, rdy0}, 32'(1 << k));
      applyStimulus();
      checkOutput("sel_data", q0, 32'hA0 + 32'(k));
      checkOutput("sel_chan", {30'd0, c0}, 32'(k));
      checkOutput("sel_valid", {31'd0, vo0}, 32'h1);
      checkIdle3();
    end

    // Transfer 1234 from channel 2, then back-pressure for 5 cycles
    d0[64 +: 32] = 32'h1234;
    v0 = 4'b0100; s0 = 2'd2;
    #1;
    checkOutput("bp_ready_first", {28'd0, rdy0}, 32'h4);
    applyStimulus();
    checkOutput("bp_data_first", q0, 32'h1234);
    checkOutput("bp_chan_first", {30'd0, c0}, 32'h2);
    r0 = 1'b0; v0 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("bp_ready_hold", {28'd0, rdy0}, 32'h0);
      applyStimulus();
      checkOutput("bp_data_hold", q0, 32'h1234);
      checkOutput("bp_valid_hold", {31'd0, vo0}, 32'h1);
      checkOutput("bp_chan_hold", {30'd0, c0}, 32'h2);
    end

    // Release with a new channel: consume and replace in the same cycle
    d0[32 +: 32] = 32'h5678;
    r0 = 1'b1; s0 = 2'd1;
    #1;
    checkOutput("bp_ready_release", {28'd0, rdy0}, 32'h2);
    applyStimulus();
    checkOutput("bp_data_replace", q0, 32'h5678);
    checkOutput("bp_chan_replace", {30'd0, c0}, 32'h1);
    checkOutput("bp_valid_stays", {31'd0, vo0}, 32'h1);

    // Bare consume: valid drops, data and channel held
    v0 = 4'h0;
    applyStimulus();
    checkOutput("consume_valid", {31'd0, vo0}, 32'h0);
    checkOutput("consume_data", q0, 32'h5678);
    checkOutput("consume_chan", {30'd0, c0}, 32'h1);

    // Round-robin with every channel valid: 0,1,2,3,0,1
    v1 = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("rr_ready", {28'd0, rdy1}, 32'(1 << rr_a[k]));
      applyStimulus();
      checkOutput("rr_chan", {30'd0, c1}, 32'(rr_a[k]));
      checkOutput("rr_data", q1, 32'hB0 + 32'(rr_a[k]));
    end

    // Channel 1 dropped: 2,3,0,2,3
    v1 = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("rr_skip_chan", {30'd0, c1}, 32'(rr_b[k]));
      checkOutput("rr_skip_valid", {31'd0, vo1}, 32'h1);
    end

    // Wrap: only channel 3, then only channel 0
    v1 = 4'b1000;
    applyStimulus();
    checkOutput("wrap_chan3", {30'd0, c1}, 32'h3);
    v1 = 4'b0001;
    #1;
    checkOutput("wrap_ready0", {28'd0, rdy1}, 32'h1);
    applyStimulus();
    checkOutput("wrap_chan0", {30'd0, c1}, 32'h0);
    checkOutput("wrap_data0", q1, 32'hB0);

    // Idle: valid falls after the consume, data held
    v1 = 4'h0;
    applyStimulus();
    checkOutput("idle_valid", {31'd0, vo1}, 32'h0);
    checkOutput("idle_data", q1, 32'hB0);
    checkIdle3();

    // Load both slots, then stall them
    v1 = 4'b0100; r1 = 1'b1;
    v0 = 4'b0001; s0 = 2'd0; r0 = 1'b1;
    applyStimulus();
    checkOutput("pre_rst_chan1", {30'd0, c1}, 32'h2);
    checkOutput("pre_rst_data0", q0, 32'hA0);
    r0 = 1'b0; r1 = 1'b0;
    v0 = 4'hF; v1 = 4'hF;
    applyStimulus();
    checkOutput("pre_rst_valid1", {31'd0, vo1}, 32'h1);

    // Reset mid-operation discards the held entries
    rst_i = 1'b1; r0 = 1'b1; r1 = 1'b1;
    #1;
    checkOutput("midrst_ready0", {28'd0, rdy0}, 32'h0);
    checkOutput("midrst_ready1", {28'd0, rdy1}, 32'h0);
    applyStimulus();
    checkOutput("midrst_valid0", {31'd0, vo0}, 32'h0);
    checkOutput("midrst_data0", q0, 32'h0);
    checkOutput("midrst_chan0", {30'd0, c0}, 32'h0);
    checkOutput("midrst_valid1", {31'd0, vo1}, 32'h0);
    checkOutput("midrst_data1", q1, 32'h0);
    checkOutput("midrst_chan1", {30'd0, c1}, 32'h0);
    checkOutput("midrst_ready1_hold", {28'd0, rdy1}, 32'h0);

    // First round-robin grant after reset goes to channel 0
    v0 = 4'h0;
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_ready1", {28'd0, rdy1}, 32'h1);
    applyStimulus();
    checkOutput("post_rst_chan1", {30'd0, c1}, 32'h0);
    checkOutput("post_rst_data1", q1, 32'hB0);
    checkOutput("post_rst_valid1", {31'd0, vo1}, 32'h1);
    checkIdle3();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
